// File: rtl/memory_island_pkg.sv
// Shared types and constants for the memory island bank-group scheduler.
package memory_island_pkg;

    typedef enum logic {
        NARROW_PRIO = 1'b0,
        WIDE_PRIO   = 1'b1
    } sched_state_e;

    localparam int unsigned MaxWideStallDefault = 3;
    localparam logic [7:0]  StallCntMax         = '1;

endpackage

// File: rtl/sched_tag_pipe.sv
// Fixed-depth shift register carrying grant tags until the bank read data returns.
module sched_tag_pipe #(
    parameter int unsigned Width = 5,
    parameter int unsigned Depth = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] tag_i,
    output logic [Width-1:0] tag_o
);

    logic [Width-1:0] stages [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= tag_i;
            for (int unsigned i = 1; i < Depth; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_o = stages[Depth-1];

endmodule

// File: rtl/bank_group_scheduler.sv
// Arbitrates one wide bank between NumNarrow narrow slots and a wide port,
// forcing wide priority after MaxWideStall consecutive denied wide cycles.
module bank_group_scheduler
    import memory_island_pkg::*;
#(
    parameter int unsigned NumNarrow     = 4,
    parameter int unsigned AccessLatency = 1,
    parameter int unsigned MaxWideStall  = MaxWideStallDefault
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumNarrow-1:0] narrow_req_valid_i,
    output logic [NumNarrow-1:0] narrow_req_ready_o,
    output logic [NumNarrow-1:0] narrow_rsp_valid_o,
    input  logic                 wide_req_valid_i,
    output logic                 wide_req_ready_o,
    output logic                 wide_rsp_valid_o,
    output logic [NumNarrow-1:0] bank_req_o,
    output logic                 bank_sel_wide_o,
    output logic                 wide_prio_o
);

    localparam logic [7:0] StallLimit = 8'(MaxWideStall);

    sched_state_e state_q, state_d;
    logic [7:0]   stall_cnt_q, stall_cnt_d;
    logic         any_narrow;
    logic         wide_denied;

    assign any_narrow = |narrow_req_valid_i;

    always_comb begin
        narrow_req_ready_o = '0;
        wide_req_ready_o   = 1'b0;
        state_d            = state_q;
        stall_cnt_d        = '0;

        case (state_q)
            NARROW_PRIO: begin
                narrow_req_ready_o = narrow_req_valid_i;
                wide_req_ready_o   = wide_req_valid_i && !any_narrow;
            end
            WIDE_PRIO: begin
                wide_req_ready_o = wide_req_valid_i;
            end
            default: ;
        endcase

        wide_denied = wide_req_valid_i && !wide_req_ready_o;

        if (wide_denied) begin
            stall_cnt_d = (stall_cnt_q == StallCntMax) ? stall_cnt_q : stall_cnt_q + 8'd1;
        end

        // WIDE_PRIO lasts exactly one cycle: either the wide grant or its withdrawal.
        case (state_q)
            NARROW_PRIO: begin
                if (wide_denied && (stall_cnt_d >= StallLimit)) begin
                    state_d = WIDE_PRIO;
                end
            end
            WIDE_PRIO: begin
                state_d = NARROW_PRIO;
            end
            default: begin
                state_d = NARROW_PRIO;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= NARROW_PRIO;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bank_req_o      = wide_req_ready_o ? '1 : narrow_req_ready_o;
    assign bank_sel_wide_o = wide_req_ready_o;
    assign wide_prio_o     = (state_q == WIDE_PRIO);

    sched_tag_pipe #(
        .Width (NumNarrow + 1),
        .Depth (AccessLatency)
    ) i_tag_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tag_i  ({wide_req_ready_o, narrow_req_ready_o}),
        .tag_o  ({wide_rsp_valid_o, narrow_rsp_valid_o})
    );

endmodule
